// File: rtl/hack_pkg.sv
// Shared memory-map constants and screen-scanner state encoding for the Hack data memory.
package hack_pkg;

  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam logic [15:0] SCREEN_BASE = 16'h4000;
  localparam logic [15:0] KBD_ADDR    = 16'h6000;

  localparam int SCR_ADDR_W = 13;

  typedef enum logic [1:0] {
    SCAN_IDLE    = 2'd0,
    SCAN_FETCH   = 2'd1,
    SCAN_PRESENT = 2'd2
  } scan_state_t;

  // Next scan index, wrapping from the last screen word back to 0.
  function automatic logic [SCR_ADDR_W-1:0] scan_next(
    input logic [SCR_ADDR_W-1:0] idx,
    input logic [SCR_ADDR_W-1:0] last
  );
    return (idx == last) ? '0 : idx + SCR_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/hack_data_mem_if.sv
// CPU data bus plus display-sink stream of the Hack data memory.
interface hack_data_mem_if;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        wen;
  logic [15:0] inM;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_valid;
  logic        scr_ready;
  logic        scr_sof;

  modport master (
    output addressM, outM, wen, scr_ready,
    input  inM, scr_addr, scr_data, scr_valid, scr_sof
  );

  modport slave (
    input  addressM, outM, wen, scr_ready,
    output inM, scr_addr, scr_data, scr_valid, scr_sof
  );
endinterface

// File: rtl/hack_screen_scan.sv
// Screen scanner: walks the screen RAM through a read-only synchronous port and
// hands each word to the display sink with a valid/ready handshake.
module hack_screen_scan
  import hack_pkg::*;
#(
  parameter int SCREEN_WORDS = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [SCR_ADDR_W-1:0] scan_idx_o,
  input  logic [15:0]           scan_word_i,
  input  logic                  scr_ready_i,
  output logic [SCR_ADDR_W-1:0] scr_addr_o,
  output logic [15:0]           scr_data_o,
  output logic                  scr_valid_o,
  output logic                  scr_sof_o
);

  localparam logic [SCR_ADDR_W-1:0] LAST_IDX = SCR_ADDR_W'(SCREEN_WORDS - 1);

  scan_state_t           state_q;
  logic [SCR_ADDR_W-1:0] idx_q;
  logic [SCR_ADDR_W-1:0] addr_q;
  logic [15:0]           data_q;
  logic                  valid_q;
  logic                  sof_q;

  assign scan_idx_o  = idx_q;
  assign scr_addr_o  = addr_q;
  assign scr_data_o  = data_q;
  assign scr_valid_o = valid_q;
  assign scr_sof_o   = sof_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      case (state_q)
        SCAN_IDLE: begin
          idx_q   <= '0;
          state_q <= SCAN_FETCH;
        end
        SCAN_FETCH: begin
          // Array contents sampled before this edge's CPU write lands: old data wins.
          data_q  <= scan_word_i;
          addr_q  <= idx_q;
          valid_q <= 1'b1;
          sof_q   <= (idx_q == '0);
          state_q <= SCAN_PRESENT;
        end
        SCAN_PRESENT: begin
          if (scr_ready_i) begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            idx_q   <= scan_next(idx_q, LAST_IDX);
            state_q <= SCAN_FETCH;
          end
        end
        default: state_q <= SCAN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hack_data_mem.sv
// Hack data memory: general RAM, screen RAM and keyboard register behind the CPU
// data bus, with the screen scanner streaming screen words to a display sink.
module hack_data_mem #(
  parameter int          RAM_WORDS    = 16384,
  parameter int          SCREEN_WORDS = 8192,
  parameter logic [15:0] KBD_ADDR     = hack_pkg::KBD_ADDR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     kbd,
  hack_data_mem_if.slave  bus
);
  import hack_pkg::*;

  localparam int          RAM_IDX_W  = $clog2(RAM_WORDS);
  localparam int          SCR_IDX_W  = $clog2(SCREEN_WORDS);
  localparam logic [15:0] RAM_LIMIT  = 16'(RAM_WORDS);
  localparam logic [15:0] SCR_LIMIT  = 16'(SCREEN_WORDS);

  logic [15:0] ram_mem [RAM_WORDS];
  logic [15:0] scr_mem [SCREEN_WORDS];

  logic [15:0]           cpu_addr;
  logic [15:0]           ram_off;
  logic [15:0]           scr_off;
  logic                  ram_sel;
  logic                  scr_sel;
  logic                  kbd_sel;
  logic [RAM_IDX_W-1:0]  ram_idx;
  logic [SCR_IDX_W-1:0]  scr_idx;
  logic [15:0]           rd_data;
  logic [15:0]           kbd_q;
  logic [SCR_ADDR_W-1:0] scan_idx;
  logic [15:0]           scan_word;

  assign cpu_addr = bus.addressM & 16'h7FFF;

  // Offsets below a region's base wrap to large values, so one unsigned
  // compare per region covers both bounds.
  always_comb begin
    ram_off = cpu_addr - RAM_BASE;
    scr_off = cpu_addr - SCREEN_BASE;
    ram_sel = (cpu_addr < SCREEN_BASE) && (ram_off < RAM_LIMIT);
    scr_sel = (cpu_addr < KBD_ADDR) && (scr_off < SCR_LIMIT);
    kbd_sel = (cpu_addr == KBD_ADDR);
  end

  assign ram_idx = ram_off[RAM_IDX_W-1:0];
  assign scr_idx = scr_off[SCR_IDX_W-1:0];

  always_comb begin
    rd_data = '0;
    if (ram_sel) begin
      rd_data = ram_mem[ram_idx];
    end else if (scr_sel) begin
      rd_data = scr_mem[scr_idx];
    end else if (kbd_sel) begin
      rd_data = kbd_q;
    end
  end

  assign bus.inM = rd_data;

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.wen && ram_sel) begin
      ram_mem[ram_idx] <= bus.outM;
    end
    if (bus.wen && scr_sel) begin
      scr_mem[scr_idx] <= bus.outM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_q <= '0;
    end else begin
      kbd_q <= kbd;
    end
  end

  assign scan_word = scr_mem[SCR_IDX_W'(scan_idx)];

  hack_screen_scan #(
    .SCREEN_WORDS (SCREEN_WORDS)
  ) u_scan (
    .clk         (clk),
    .reset       (reset),
    .scan_idx_o  (scan_idx),
    .scan_word_i (scan_word),
    .scr_ready_i (bus.scr_ready),
    .scr_addr_o  (bus.scr_addr),
    .scr_data_o  (bus.scr_data),
    .scr_valid_o (bus.scr_valid),
    .scr_sof_o   (bus.scr_sof)
  );

endmodule

// File: tb/tb_hack_data_mem.sv
// Self-checking bench for hack_data_mem: table vectors, randomized CPU traffic
// against a memory-map model, and a full screen scan with handshake corner cases.
module tb_hack_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] kbd;

  hack_data_mem_if bus();

  hack_data_mem dut (
    .clk   (clk),
    .reset (reset),
    .kbd   (kbd),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] ram_m [int];
  logic [15:0] scr_m [int];
  logic [15:0] kbd_m = 16'h0000;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        wen;
    logic [15:0] kbd;
    logic        pre_chk;
    logic [15:0] pre;
    logic [15:0] post;
  } vec_t;

  vec_t vecs [19];

  logic [15:0] pool [12] = '{16'h0011, 16'h1234, 16'h3000, 16'h3FFF, 16'h4001, 16'h4005,
                             16'h4020, 16'h5FFF, 16'h6000, 16'h6001, 16'h7000, 16'h7FFF};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  function automatic logic model_known(input logic [15:0] a);
    int ai = int'(a & 16'h7FFF);
    if (ai < 'h4000) return ram_m.exists(ai);
    if (ai < 'h6000) return scr_m.exists(ai - 'h4000);
    return 1'b1;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    int ai = int'(a & 16'h7FFF);
    if (ai < 'h4000) return ram_m[ai];
    if (ai < 'h6000) return scr_m[ai - 'h4000];
    if (ai == 'h6000) return kbd_m;
    return 16'h0000;
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [15:0] d);
    int ai = int'(a & 16'h7FFF);
    if (ai < 'h4000) ram_m[ai] = d;
    else if (ai < 'h6000) scr_m[ai - 'h4000] = d;
  endfunction

  function automatic logic [15:0] pat(input int i);
    if (i == 0) return 16'hFFFF;
    return 16'(i * 40503) ^ 16'h1357;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply the model's view of the coming edge, then let the edge happen.
  task automatic step();
    if (bus.wen) model_write(bus.addressM, bus.outM);
    kbd_m = reset ? 16'h0000 : kbd;
    tick();
  endtask

  initial begin
    int exp_idx, accepts, last_acc, cyc, w;
    bit done_stall, done_fetchwr, pend;
    int pend_idx;
    logic [15:0] pend_val, held, a, d, k;
    logic wr;

    vecs[0]  = '{16'h0010, 16'h000a, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h000a};
    vecs[1]  = '{16'h0010, 16'h5555, 1'b0, 16'h0000, 1'b1, 16'h000a, 16'h000a};
    vecs[2]  = '{16'h4000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'hFFFF};
    vecs[3]  = '{16'h4000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF};
    vecs[4]  = '{16'h6000, 16'h0000, 1'b0, 16'h0041, 1'b1, 16'h0000, 16'h0041};
    vecs[5]  = '{16'h6000, 16'h1234, 1'b1, 16'h0041, 1'b1, 16'h0041, 16'h0041};
    vecs[6]  = '{16'h3000, 16'h1111, 1'b1, 16'h0041, 1'b0, 16'h0000, 16'h1111};
    vecs[7]  = '{16'h7000, 16'hBEEF, 1'b1, 16'h0041, 1'b1, 16'h0000, 16'h0000};
    vecs[8]  = '{16'h3000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h1111};
    vecs[9]  = '{16'h6000, 16'h0000, 1'b0, 16'h0077, 1'b1, 16'h0000, 16'h0077};
    vecs[10] = '{16'h6001, 16'h0000, 1'b0, 16'h0077, 1'b1, 16'h0000, 16'h0000};
    vecs[11] = '{16'h8010, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h000a, 16'h000a};
    vecs[12] = '{16'hC020, 16'h2468, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h2468};
    vecs[13] = '{16'h4020, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h2468, 16'h2468};
    vecs[14] = '{16'h3FFF, 16'hA5A5, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'hA5A5};
    vecs[15] = '{16'h5FFF, 16'h5A5A, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h5A5A};
    vecs[16] = '{16'h4000, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF};
    vecs[17] = '{16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h000a, 16'h000a};
    vecs[18] = '{16'h6000, 16'h9999, 1'b1, 16'h0000, 1'b1, 16'h0000, 16'h0000};

    // Reset: keyboard register held at 0 even with a key pressed.
    reset = 1'b1;
    kbd = 16'h0055;
    bus.addressM = 16'h6000;
    bus.outM = 16'h0000;
    bus.wen = 1'b0;
    bus.scr_ready = 1'b0;
    step();
    step();
    check("rst_kbd_inM", bus.inM, 16'h0000);
    check("rst_valid", {15'b0, bus.scr_valid}, 16'd0);
    check("rst_sof", {15'b0, bus.scr_sof}, 16'd0);
    check("rst_addr", {3'b0, bus.scr_addr}, 16'd0);
    check("rst_data", bus.scr_data, 16'h0000);
    reset = 1'b0;
    kbd = 16'h0000;

    for (int i = 0; i < 19; i++) begin
      bus.addressM = vecs[i].addr;
      bus.outM = vecs[i].data;
      bus.wen = vecs[i].wen;
      kbd = vecs[i].kbd;
      #1;
      if (vecs[i].pre_chk) check($sformatf("vec%0d_pre", i), bus.inM, vecs[i].pre);
      step();
      check($sformatf("vec%0d_post", i), bus.inM, vecs[i].post);
      $display("[TB] vec %0d addr=%04h wen=%0b data=%04h kbd=%04h inM=%04h",
               i, vecs[i].addr, vecs[i].wen, vecs[i].data, vecs[i].kbd, bus.inM);
    end
    bus.wen = 1'b0;

    for (int i = 0; i < 300; i++) begin
      a = pool[$urandom_range(0, 11)] | ($urandom_range(0, 1) != 0 ? 16'h8000 : 16'h0000);
      wr = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      k = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0000;
      bus.addressM = a;
      bus.outM = d;
      bus.wen = wr;
      kbd = k;
      #1;
      if (model_known(a)) check($sformatf("rnd%0d_pre", i), bus.inM, model_read(a));
      step();
      if (model_known(a)) check($sformatf("rnd%0d_post", i), bus.inM, model_read(a));
      $display("[TB] rnd %0d addr=%04h wen=%0b data=%04h kbd=%04h inM=%04h",
               i, a, wr, d, k, bus.inM);
    end
    bus.wen = 1'b0;
    kbd = 16'h0000;

    // Fill the whole screen so every scanned word has a known value.
    for (int i = 0; i < 8192; i++) begin
      bus.addressM = 16'(16'h4000 + i);
      bus.outM = pat(i);
      bus.wen = 1'b1;
      step();
    end
    bus.wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.addressM = (i == 0) ? 16'h4001 : ((i == 1) ? 16'h4FFF : 16'h5FFF);
      #1;
      check("fill_readback", bus.inM, model_read(bus.addressM));
    end

    // Reset while the scanner sits in PRESENT, then scan a full frame and a bit.
    reset = 1'b1;
    step();
    check("rst_in_present_valid", {15'b0, bus.scr_valid}, 16'd0);
    reset = 1'b0;
    bus.scr_ready = 1'b1;

    exp_idx = 0; accepts = 0; last_acc = -1; cyc = 0;
    done_stall = 0; done_fetchwr = 0; pend = 0; pend_idx = 0; pend_val = '0;
    while (accepts < 8195 && cyc < 20000) begin
      tick();
      cyc++;
      bus.wen = 1'b0;
      if (bus.scr_valid) begin
        check("scan_addr", {3'b0, bus.scr_addr}, 16'(exp_idx));
        check("scan_data", bus.scr_data, scr_m[exp_idx]);
        check("scan_sof", {15'b0, bus.scr_sof}, (exp_idx == 0) ? 16'd1 : 16'd0);
        if (accepts == 0) check("first_word_data", bus.scr_data, 16'hFFFF);
        if (accepts == 8192) check("wrap_sof", {15'b0, bus.scr_sof}, 16'd1);
        if (last_acc >= 0) check("scan_gap", 16'(cyc - last_acc), 16'd2);
        if (pend && exp_idx == pend_idx) begin
          scr_m[pend_idx] = pend_val;
          pend = 0;
          bus.addressM = 16'(16'h4000 + pend_idx);
          #1;
          check("fetch_write_landed", bus.inM, pend_val);
        end
        if (exp_idx == 100 && !done_stall) begin
          held = scr_m[100];
          bus.scr_ready = 1'b0;
          bus.addressM = 16'h4064;
          bus.outM = 16'hDEAD;
          bus.wen = 1'b1;
          scr_m[100] = 16'hDEAD;
          for (int s = 0; s < 5; s++) begin
            tick();
            cyc++;
            bus.wen = 1'b0;
            check("stall_valid", {15'b0, bus.scr_valid}, 16'd1);
            check("stall_addr", {3'b0, bus.scr_addr}, 16'd100);
            check("stall_data", bus.scr_data, held);
          end
          bus.scr_ready = 1'b1;
          done_stall = 1;
        end
        last_acc = cyc;
        accepts++;
        exp_idx = (exp_idx + 1) % 8192;
      end else if (exp_idx == 300 && !done_fetchwr) begin
        pend = 1;
        pend_idx = 300;
        pend_val = 16'hBEEF;
        bus.addressM = 16'h412C;
        bus.outM = 16'hBEEF;
        bus.wen = 1'b1;
        done_fetchwr = 1;
      end
    end
    bus.wen = 1'b0;
    check("scan_accepts", 16'(accepts), 16'd8195);
    $display("[TB] scan accepted %0d words in %0d cycles", accepts, cyc);

    bus.addressM = 16'h7000;
    #1;
    check("above_kbd_inM", bus.inM, 16'h0000);

    // Reset pulse while word 5 is being presented.
    w = 0;
    while (!(bus.scr_valid && bus.scr_addr == 13'd5) && w < 50) begin
      tick();
      w++;
    end
    check("reach_addr5", {15'b0, bus.scr_valid && bus.scr_addr == 13'd5}, 16'd1);
    reset = 1'b1;
    step();
    check("rst5_valid", {15'b0, bus.scr_valid}, 16'd0);
    check("rst5_sof", {15'b0, bus.scr_sof}, 16'd0);
    check("rst5_addr", {3'b0, bus.scr_addr}, 16'd0);
    check("rst5_data", bus.scr_data, 16'h0000);
    reset = 1'b0;
    w = 0;
    while (!bus.scr_valid && w < 10) begin
      tick();
      w++;
    end
    check("restart_latency", 16'(w), 16'd2);
    check("restart_addr", {3'b0, bus.scr_addr}, 16'd0);
    check("restart_sof", {15'b0, bus.scr_sof}, 16'd1);
    check("restart_data", bus.scr_data, 16'hFFFF);
    bus.addressM = 16'h0010;
    #1;
    check("ram_retained", bus.inM, 16'h000a);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hack_data_mem.md
HACK_DATA_MEM -- requirements
Module: hack_data_mem

Interface
REQ-001 SHALL expose parameter RAM_WORDS, default 16384, general-purpose RAM depth at 0x0000-0x3FFF.
REQ-002 SHALL expose parameter SCREEN_WORDS, default 8192, screen RAM depth at 0x4000-0x5FFF.
REQ-003 SHALL expose parameter KBD_ADDR, default 16'h6000, keyboard register address.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 addressM  input  16  CPU data address; bit 15 ignored.
REQ-007 outM  input  16  CPU write data.
REQ-008 wen  input  1  CPU write enable.
REQ-009 inM  output  16  CPU read data.
REQ-010 kbd  input  16  raw key code from keyboard source; 0 = no key.
REQ-011 scr_addr  output  13  screen word index of scr_data.
REQ-012 scr_data  output  16  screen word for display sink.
REQ-013 scr_valid  output  1  scr_addr/scr_data valid.
REQ-014 scr_ready  input  1  display sink accepts word.
REQ-015 scr_sof  output  1  high with the scr_valid word at index 0 (start of frame).

Function
REQ-016 inM SHALL be combinational from addressM[14:0]: RAM word, screen word, keyboard register, or 16'h0000 for addresses above KBD_ADDR.
REQ-017 On a rising edge with wen=1, outM SHALL be written to the addressed RAM or screen word; writes to KBD_ADDR or above SHALL be ignored.
REQ-018 A word written at edge N SHALL appear on inM from edge N onward when addressM selects it.
REQ-019 Keyboard register SHALL load kbd every cycle (one-cycle latency to inM).
REQ-020 Screen RAM SHALL have a second, read-only synchronous port for the scanner, read latency one cycle.
REQ-021 Scanner FSM states: IDLE, FETCH, PRESENT.
REQ-022 IDLE -> FETCH on the cycle after reset deasserts; scan index = 0.
REQ-023 FETCH: issue scan read of scan index; -> PRESENT next cycle; scr_valid=0.
REQ-024 PRESENT: scr_valid=1, scr_addr/scr_data held stable until scr_ready=1.
REQ-025 On scr_valid & scr_ready: scan index increments, wrapping SCREEN_WORDS-1 -> 0; -> FETCH.
REQ-026 Throughput SHALL be one word per two cycles with scr_ready held high.
REQ-027 scr_sof SHALL equal scr_valid & (scr_addr==0).
REQ-028 CPU write and scan read of the same screen word on the same edge: scanner SHALL return the old value (read-before-write).
REQ-029 A CPU write to a word already fetched but not yet accepted SHALL NOT alter the presented scr_data.

Reset
REQ-030 On reset: inM follows REQ-016; keyboard register = 0; scr_valid=0, scr_sof=0, scr_addr=0, scr_data=0; FSM=IDLE; scan index=0.
REQ-031 Reset SHALL NOT clear RAM or screen contents.
REQ-032 Reset asserted mid-PRESENT SHALL drop scr_valid at that edge with no handshake completion.

Structure
REQ-033 Memory map constants (RAM_BASE, SCREEN_BASE, KBD_ADDR) and scanner state encoding SHALL live in shared package hack_pkg.
REQ-034 Scanner FSM plus its read port SHALL be sub-module hack_screen_scan; RAM arrays and decode stay in hack_data_mem.

Verification
REQ-035 addressM=0x0010, outM=0x000a, wen=1 for one edge, then wen=0 -> inM=0x000a while addressM=0x0010.
REQ-036 Write 0xFFFF to 0x4000, scr_ready=1 -> first scr_valid word has scr_addr=0, scr_data=0xFFFF, scr_sof=1.
REQ-037 kbd=0x0041, addressM=0x6000 -> inM=0x0041 one edge later; wen=1 outM=0x1234 at 0x6000 -> no change.
REQ-038 scr_ready=0 for 5 cycles in PRESENT -> scr_addr/scr_data stable, scr_valid=1 throughout.
REQ-039 Run 8192 accepts -> scr_addr wraps 8191 -> 0 with scr_sof=1; addressM=0x7000 -> inM=0x0000.
REQ-040 Reset pulse during PRESENT at scr_addr=5 -> scr_valid=0 same edge; restart at scr_addr=0; RAM word 0x0010 retains 0x000a.
